// File: rtl/rc6_pkg.sv
// Shared types and helpers for the RC6-32 decrypt core.
// RC6_ROUND_PIPE_EN (defined in the core) selects the two-cycle round; the ROUND_MUL/ROUND_ROT states serve that build.
package rc6_pkg;

    localparam int W   = 32;
    localparam int LGW = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ROUND,
        ST_ROUND_MUL,
        ST_ROUND_ROT,
        ST_POST,
        ST_DONE
    } rc6_state_e;

    function automatic int key_words(input int rounds);
        return 2 * rounds + 4;
    endfunction

    function automatic logic [W-1:0] rotl5(input logic [W-1:0] x);
        return {x[W-LGW-1:0], x[W-1:W-LGW]};
    endfunction

endpackage

// File: rtl/rc6_dyn_rot_right.sv
// Combinational data-dependent right rotate; undoes the encrypt-side left rotator.
module rc6_dyn_rot_right
    import rc6_pkg::*;
(
    input  logic [LGW-1:0] i_amt,
    input  logic [W-1:0]   i_data,
    output logic [W-1:0]   o_data
);

    // A zero amount shifts the left term by the full width, which clears it.
    assign o_data = (i_data >> i_amt) | (i_data << (6'd32 - {1'b0, i_amt}));

endmodule

// File: rtl/rc6_decrypt_core.sv
// Iterative RC6-32 block decryptor with an on-chip round-key file and valid/ready on both sides.
// Define RC6_ROUND_PIPE_EN to register the u/t products, making each round two cycles.
module rc6_decrypt_core
    import rc6_pkg::*;
#(
    parameter int ROUNDS = 20,
    parameter int KEY_AW = 6
) (
    input  logic              inClk,
    input  logic              inRst,
    input  logic              inKeyWe,
    input  logic [KEY_AW-1:0] inKeyAddr,
    input  logic [W-1:0]      inKeyData,
    input  logic              inValid,
    output logic              outReady,
    input  logic [4*W-1:0]    inBlock,
    output logic              outValid,
    input  logic              inReady,
    output logic [4*W-1:0]    outBlock,
    output logic              outBusy,
    output logic              outKeyWrErr
);

    localparam int KEY_WORDS = key_words(ROUNDS);
`ifdef RC6_ROUND_PIPE_EN
    localparam rc6_state_e ST_FIRST = ST_ROUND_MUL;
`else
    localparam rc6_state_e ST_FIRST = ST_ROUND;
`endif

    rc6_state_e        r_state;
    logic [W-1:0]      r_a, r_b, r_c, r_d;
    logic [KEY_AW-1:0] r_idx;
    logic [W-1:0]      r_key [KEY_WORDS];
    logic              r_ready, r_valid, r_busy, r_keyWrErr;
    logic [4*W-1:0]    r_out;

    // Words after undoing the encrypt-side (A,B,C,D) <- (B,C,D,A) shuffle.
    logic [W-1:0] w_ra, w_rb, w_rc, w_rd;
    assign w_ra = r_d;
    assign w_rb = r_a;
    assign w_rc = r_b;
    assign w_rd = r_c;

    logic [W-1:0] w_u, w_t, w_uUse, w_tUse;
    assign w_u = rotl5(w_rd * {w_rd[W-2:0], 1'b1});
    assign w_t = rotl5(w_rb * {w_rb[W-2:0], 1'b1});

`ifdef RC6_ROUND_PIPE_EN
    logic [W-1:0] r_u, r_t;
    assign w_uUse = r_u;
    assign w_tUse = r_t;
`else
    assign w_uUse = w_u;
    assign w_tUse = w_t;
`endif

    logic [KEY_AW-1:0] w_kEven, w_kOdd;
    assign w_kEven = {r_idx[KEY_AW-2:0], 1'b0};
    assign w_kOdd  = {r_idx[KEY_AW-2:0], 1'b1};

    logic [W-1:0] w_aSub, w_cSub, w_aRot, w_cRot, w_aNew, w_cNew;
    assign w_aSub = w_ra - r_key[w_kEven];
    assign w_cSub = w_rc - r_key[w_kOdd];

    // A rotates by u and folds in t; C rotates by t and folds in u.
    rc6_dyn_rot_right u_rot_a (.i_amt(w_uUse[LGW-1:0]), .i_data(w_aSub), .o_data(w_aRot));
    rc6_dyn_rot_right u_rot_c (.i_amt(w_tUse[LGW-1:0]), .i_data(w_cSub), .o_data(w_cRot));

    assign w_aNew = w_aRot ^ w_tUse;
    assign w_cNew = w_cRot ^ w_uUse;

    logic w_keyInRange;
    assign w_keyInRange = ({1'b0, inKeyAddr} < (KEY_AW+1)'(KEY_WORDS));

    // Not reset: the key survives a datapath reset.
    always_ff @(posedge inClk) begin
        if (inKeyWe && !r_busy && w_keyInRange)
            r_key[inKeyAddr] <= inKeyData;
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_keyWrErr <= 1'b0;
            r_out      <= '0;
        end else begin
            r_keyWrErr <= inKeyWe && r_busy;
            case (r_state)
                ST_IDLE: begin
                    if (inValid && r_ready) begin
                        {r_a, r_b, r_c, r_d} <= inBlock;
                        r_state <= ST_PRE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PRE: begin
                    r_a     <= r_a - r_key[KEY_WORDS-2];
                    r_c     <= r_c - r_key[KEY_WORDS-1];
                    r_idx   <= KEY_AW'(ROUNDS);
                    r_state <= ST_FIRST;
                end
`ifdef RC6_ROUND_PIPE_EN
                ST_ROUND_MUL: begin
                    r_u     <= w_u;
                    r_t     <= w_t;
                    r_state <= ST_ROUND_ROT;
                end
                ST_ROUND_ROT: begin
`else
                ST_ROUND: begin
`endif
                    r_a     <= w_aNew;
                    r_b     <= w_rb;
                    r_c     <= w_cNew;
                    r_d     <= w_rd;
                    r_idx   <= r_idx - KEY_AW'(1);
                    r_state <= (r_idx == KEY_AW'(1)) ? ST_POST : ST_FIRST;
                end
                ST_POST: begin
                    r_out   <= {r_a, r_b - r_key[0], r_c, r_d - r_key[1]};
                    r_valid <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (inReady) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign outReady    = r_ready;
    assign outValid    = r_valid;
    assign outBlock    = r_out;
    assign outBusy     = r_busy;
    assign outKeyWrErr = r_keyWrErr;

endmodule

// File: tb/tb_rc6_decrypt_core.sv
// Directed bench for rc6_decrypt_core: reference key schedule and encryptor feed a plaintext scoreboard.
module tb_rc6_decrypt_core;

    localparam int R  = 20;
    localparam int KW = 2 * R + 4;
    localparam int AW = 6;
`ifdef RC6_ROUND_PIPE_EN
    localparam int LAT = 2 * R + 2;
`else
    localparam int LAT = R + 2;
`endif

    logic          inClk = 1'b0;
    logic          inRst = 1'b1;
    logic          inKeyWe = 1'b0;
    logic [AW-1:0] inKeyAddr = '0;
    logic [31:0]   inKeyData = '0;
    logic          inValid = 1'b0;
    logic          outReady;
    logic [127:0]  inBlock = '0;
    logic          outValid;
    logic          inReady = 1'b1;
    logic [127:0]  outBlock;
    logic          outBusy;
    logic          outKeyWrErr;

    int nChecks = 0;
    int nPass   = 0;
    int nFail   = 0;

    logic [31:0]  km [KW];
    logic [127:0] sb [$];

    rc6_decrypt_core #(.ROUNDS(R), .KEY_AW(AW)) dut (
        .inClk      (inClk),
        .inRst      (inRst),
        .inKeyWe    (inKeyWe),
        .inKeyAddr  (inKeyAddr),
        .inKeyData  (inKeyData),
        .inValid    (inValid),
        .outReady   (outReady),
        .inBlock    (inBlock),
        .outValid   (outValid),
        .inReady    (inReady),
        .outBlock   (outBlock),
        .outBusy    (outBusy),
        .outKeyWrErr(outKeyWrErr)
    );

    always #5 inClk = ~inClk;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] p);
        logic [31:0] a, b, c, d, t, u, tmp;
        {a, b, c, d} = p;
        b = b + km[0];
        d = d + km[1];
        for (int i = 1; i <= R; i++) begin
            t = rotl(b * ((b << 1) + 32'd1), 5'd5);
            u = rotl(d * ((d << 1) + 32'd1), 5'd5);
            a = rotl(a ^ t, u[4:0]) + km[2*i];
            c = rotl(c ^ u, t[4:0]) + km[2*i+1];
            tmp = a; a = b; b = c; c = d; d = tmp;
        end
        a = a + km[2*R+2];
        c = c + km[2*R+3];
        return {a, b, c, d};
    endfunction

    task automatic keysched(input logic [31:0] l0, l1, l2, l3);
        logic [31:0] L [4];
        logic [31:0] a, b, ab;
        int ii, jj;
        L[0] = l0; L[1] = l1; L[2] = l2; L[3] = l3;
        km[0] = 32'hB7E15163;
        for (int k = 1; k < KW; k++) km[k] = km[k-1] + 32'h9E3779B9;
        a = '0; b = '0; ii = 0; jj = 0;
        for (int k = 0; k < 3 * KW; k++) begin
            a = rotl(km[ii] + a + b, 5'd3);
            km[ii] = a;
            ab = a + b;
            b = rotl(L[jj] + ab, ab[4:0]);
            L[jj] = b;
            ii = (ii + 1) % KW;
            jj = (jj + 1) % 4;
        end
    endtask

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        assert (obs === exp) begin
            nPass++;
        end else begin
            nFail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_key(input logic [AW-1:0] addr, input logic [31:0] data);
        inKeyWe = 1'b1; inKeyAddr = addr; inKeyData = data;
        tick();
        inKeyWe = 1'b0;
    endtask

    task automatic load_keys();
        for (int k = 0; k < KW; k++) write_key(AW'(k), km[k]);
    endtask

    task automatic accept(input logic [127:0] ct);
        int cyc = 0;
        while (!outReady && cyc < 100) begin tick(); cyc++; end
        if (cyc >= 100) check("ready timeout", {127'b0, outReady}, 128'd1);
        inBlock = ct; inValid = 1'b1;
        tick();
        inValid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!outValid && cyc < 300) begin tick(); cyc++; end
    endtask

    task automatic run(input logic [127:0] ct, input string tag);
        int cyc;
        logic [127:0] exp;
        accept(ct);
        wait_valid(cyc);
        check({tag, " latency"}, 128'(cyc), 128'(LAT));
        exp = sb.pop_front();
        check(tag, outBlock, exp);
        inReady = 1'b1;
        tick();
    endtask

    task automatic send(input logic [127:0] pt, input string tag);
        sb.push_back(pt);
        run(enc(pt), tag);
    endtask

    initial begin
        logic [127:0] pt, exp;
        logic [31:0]  oldk;
        logic [31:0]  pats [3];
        int cyc;
        pats[0] = 32'h0000001F; pats[1] = 32'hFFFFFFFF; pats[2] = 32'h80000000;

        inRst = 1'b1;
        tick(); tick();
        check("reset flags", {124'b0, outReady, outValid, outBusy, outKeyWrErr}, 128'b1000);
        check("reset block", outBlock, 128'h0);
        inRst = 1'b0;
        tick();
        check("idle flags", {124'b0, outReady, outValid, outBusy, outKeyWrErr}, 128'b1000);

        keysched('0, '0, '0, '0);
        load_keys();
        sb.push_back(128'h0);
        run(128'h36a5c38f_78f7b156_4edf29c1_1ea44898, "zero-key vector");

        for (int k = 0; k < 3; k++) send({$urandom, pats[k], $urandom, pats[k]}, "edge operand zk");
        keysched($urandom, $urandom, $urandom, $urandom);
        load_keys();
        for (int k = 0; k < 3; k++) send({pats[k], pats[k], pats[k], pats[k]}, "edge operand rk");

        // Stall in DONE for ten cycles.
        pt = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back(pt);
        inReady = 1'b0;
        accept(enc(pt));
        wait_valid(cyc);
        check("stall latency", 128'(cyc), 128'(LAT));
        exp = sb.pop_front();
        for (int k = 0; k < 10; k++) begin
            check("stall flags", {125'b0, outValid, outReady, outBusy}, 128'b101);
            check("stall block", outBlock, exp);
            tick();
        end
        inReady = 1'b1;
        tick();
        check("release flags", {125'b0, outValid, outReady, outBusy}, 128'b010);

        // Key write while busy is dropped and flagged.
        pt = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back(pt);
        accept(enc(pt));
        repeat (5) tick();
        write_key(AW'(10), ~km[10]);
        check("busy keywr pulse", {127'b0, outKeyWrErr}, 128'd1);
        tick();
        check("busy keywr clear", {127'b0, outKeyWrErr}, 128'd0);
        wait_valid(cyc);
        exp = sb.pop_front();
        check("busy keywr block", outBlock, exp);
        tick();

        // Out-of-range writes are ignored; the next block still uses the model key.
        write_key(AW'(KW), 32'hDEADBEEF);
        write_key(AW'(63), 32'hCAFEF00D);
        send({$urandom, $urandom, $urandom, $urandom}, "after oob write");

        // Key write and block accept on the same IDLE edge.
        oldk = km[KW-1];
        km[KW-1] = $urandom;
        pt = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back(pt);
        inKeyWe = 1'b1; inKeyAddr = AW'(KW-1); inKeyData = km[KW-1];
        inBlock = enc(pt); inValid = 1'b1;
        tick();
        inKeyWe = 1'b0; inValid = 1'b0;
        check("idle keywr no err", {127'b0, outKeyWrErr}, 128'd0);
        wait_valid(cyc);
        check("same-edge latency", 128'(cyc), 128'(LAT));
        exp = sb.pop_front();
        check("same-edge block", outBlock, exp);
        tick();
        km[KW-1] = oldk;
        write_key(AW'(KW-1), oldk);

        // Reset mid-block abandons it.
        accept({$urandom, $urandom, $urandom, $urandom});
        repeat (7) tick();
        inRst = 1'b1;
        tick();
        inRst = 1'b0;
        check("mid reset flags", {125'b0, outValid, outReady, outBusy}, 128'b010);
        send({$urandom, $urandom, $urandom, $urandom}, "after reset");

        for (int it = 0; it < 1000; it++) begin
            if (it % 50 == 0) begin
                keysched($urandom, $urandom, $urandom, $urandom);
                load_keys();
            end
            send({$urandom, $urandom, $urandom, $urandom}, "random");
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
